sram_port_arbiter: RTL

- Shares one sram_interface + sram_32_512_scn4m_subm pair between two fabric requesters, A and B.
- Round-robin arbitration over valid/ready request channels.
- Drives the interface command pins (csb, web, addr, conf, d_fabric_in, out_reg) from registers.
- Steers read data back to the issuing requester after a fixed, parameterised latency.
- Inserts a bubble cycle when the SRAM configuration (conf/out_reg) changes between consecutive commands.

---
 rtl/sram_port_arbiter_pkg.sv | 38 +++
 rtl/sram_port_arbiter_rsp_pipe.sv | 37 +++
 rtl/sram_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_team_pkg: shared types and defaults for the SRAM port arbiter slice.
package sram_team_pkg;

  localparam int unsigned AW_DEF = 14;
  localparam int unsigned DW_DEF = 32;

  // Requester identifiers carried through the response pipeline.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Arbiter FSM: ISSUE doubles as idle; SWITCH is the config-change bubble.
  typedef enum logic {
    ISSUE  = 1'b0,
    SWITCH = 1'b1
  } arb_state_e;

  // SRAM width/mask configuration as seen on the interface pins.
  typedef struct packed {
    logic [2:0] conf;
    logic       out_reg;
  } sram_cfg_t;

  localparam sram_cfg_t CFG_RESET = '{conf: 3'd0, out_reg: 1'b0};

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

  // The requester that is not `id`; used to advance the round-robin pointer.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rsp_pipe.sv
// sram_rsp_pipe: fixed-depth shift register of {valid, id} tags that tracks
// in-flight reads so data returning from the SRAM can be steered.
module sram_rsp_pipe
  import sram_team_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t push_i,
  output rsp_tag_t pop_o
);

  rsp_tag_t [DEPTH-1:0] stage_q;
  rsp_tag_t [DEPTH-1:0] stage_d;

  // Shift every slot one position per cycle; new tag enters slot 0.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = push_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Register the pipeline; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign pop_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM interface between requesters A and B
// with round-robin arbitration, registered command pins, a bubble on
// configuration change and latency-matched read data steering.
module sram_port_arbiter
  import sram_team_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  // requester A
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [2:0]    a_conf,
  input  logic          a_out_reg,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  // requester B
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [2:0]    b_conf,
  input  logic          b_out_reg,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  // sram interface side
  output logic          csb,
  output logic          web,
  output logic [AW-1:0] addr,
  output logic [2:0]    conf,
  output logic          out_reg,
  output logic [DW-1:0] d_fabric_in,
  input  logic [DW-1:0] d_fabric_out
);

  arb_state_e    state_q, state_d;
  req_id_e       rr_ptr_q, rr_ptr_d;
  sram_cfg_t     last_cfg_q, last_cfg_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  req_id_e       winner;
  logic          any_valid;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  sram_cfg_t     win_cfg;
  logic          cfg_match;
  logic          grant;
  rsp_tag_t      rsp_push;
  rsp_tag_t      rsp_pop;

  // Pick the winner: a lone valid requester wins, otherwise rr_ptr decides.
  always_comb begin
    any_valid = a_valid | b_valid;
    winner    = rr_ptr_q;
    if (a_valid && !b_valid) begin
      winner = REQ_A;
    end else if (b_valid && !a_valid) begin
      winner = REQ_B;
    end
  end

  // Mux the winner's command fields and compare its config to the pins.
  always_comb begin
    if (winner == REQ_A) begin
      win_we    = a_we;
      win_addr  = a_addr;
      win_wdata = a_wdata;
      win_cfg   = '{conf: a_conf, out_reg: a_out_reg};
    end else begin
      win_we    = b_we;
      win_addr  = b_addr;
      win_wdata = b_wdata;
      win_cfg   = '{conf: b_conf, out_reg: b_out_reg};
    end
    cfg_match = (win_cfg == last_cfg_q);
    grant     = (state_q == ISSUE) && any_valid && cfg_match;
    a_ready   = grant && (winner == REQ_A);
    b_ready   = grant && (winner == REQ_B);
  end

  // Next-state for FSM, command pins, rr pointer and response tag.
  always_comb begin
    state_d    = ISSUE;
    rr_ptr_d   = rr_ptr_q;
    last_cfg_d = last_cfg_q;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    addr_d     = addr_q;
    din_d      = din_q;
    rsp_push   = '0;
    if (state_q == ISSUE && any_valid) begin
      if (cfg_match) begin
        csb_d          = 1'b0;
        web_d          = ~win_we;
        addr_d         = win_addr;
        rr_ptr_d       = other_req(winner);
        rsp_push.valid = ~win_we;
        rsp_push.id    = winner;
        if (win_we) begin
          din_d = win_wdata;
        end
      end else begin
        // New config goes onto the pins now; the command itself waits for
        // the bubble so the SRAM never sees a command under a stale config.
        last_cfg_d = win_cfg;
        state_d    = SWITCH;
      end
    end
  end

  // Steer data leaving the response pipeline to its issuing requester.
  always_comb begin
    a_rvalid_d = rsp_pop.valid && (rsp_pop.id == REQ_A);
    b_rvalid_d = rsp_pop.valid && (rsp_pop.id == REQ_B);
    a_rdata_d  = a_rvalid_d ? d_fabric_out : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? d_fabric_out : b_rdata_q;
  end

  // FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ISSUE;
      rr_ptr_q   <= REQ_A;
      last_cfg_q <= CFG_RESET;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      last_cfg_q <= last_cfg_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Slot RD_LAT is reached when the SRAM data is on d_fabric_out.
  sram_rsp_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rsp_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (rsp_push),
    .pop_o  (rsp_pop)
  );

  assign csb         = csb_q;
  assign web         = web_q;
  assign addr        = addr_q;
  assign conf        = last_cfg_q.conf;
  assign out_reg     = last_cfg_q.out_reg;
  assign d_fabric_in = din_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule
